// File: rtl/ex_stage_pipe_reg.sv
// ID->EX pipeline register with a main + skid entry so that in_ready is a
// flop and the EX stall never forms a combinational path back into ID.
// Flush squashes both entries; stall_cnt counts EX back-pressure cycles.
module ex_stage_pipe_reg #(
  parameter int SCALAR_W  = 32,
  parameter int LANE_W    = 32,
  parameter int VEC_LANES = 8,
  parameter int REG_IDX_W = 5,
  parameter int CTRL_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [SCALAR_W-1:0]         in_rs1,
  input  logic [SCALAR_W-1:0]         in_rs2,
  input  logic [LANE_W*VEC_LANES-1:0] in_vrs1,
  input  logic [LANE_W*VEC_LANES-1:0] in_vrs2,
  input  logic [REG_IDX_W-1:0]        in_rs1_idx,
  input  logic [REG_IDX_W-1:0]        in_rs2_idx,
  input  logic [REG_IDX_W-1:0]        in_rd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [SCALAR_W-1:0]         out_rs1,
  output logic [SCALAR_W-1:0]         out_rs2,
  output logic [LANE_W*VEC_LANES-1:0] out_vrs1,
  output logic [LANE_W*VEC_LANES-1:0] out_vrs2,
  output logic [REG_IDX_W-1:0]        out_rs1_idx,
  output logic [REG_IDX_W-1:0]        out_rs2_idx,
  output logic [REG_IDX_W-1:0]        out_rd,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int VEC_W = LANE_W * VEC_LANES;

  // Occupancy states: main only, or main + skid.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // One buffered instruction; all fields travel together.
  typedef struct packed {
    logic [CTRL_W-1:0]    ctrl;
    logic [SCALAR_W-1:0]  rs1;
    logic [SCALAR_W-1:0]  rs2;
    logic [VEC_W-1:0]     vrs1;
    logic [VEC_W-1:0]     vrs2;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [REG_IDX_W-1:0] rd;
  } entry_t;

  logic [1:0] state, state_d;
  entry_t     in_e, main_q, skid_q;
  logic       main_v, accept, pop;
  logic       load_main, load_skid, main_from_skid;

  assign in_e = '{ctrl: in_ctrl, rs1: in_rs1, rs2: in_rs2, vrs1: in_vrs1,
                  vrs2: in_vrs2, rs1_idx: in_rs1_idx, rs2_idx: in_rs2_idx,
                  rd: in_rd};

  assign main_v = (state != ST_EMPTY);
  assign accept = in_valid & in_ready;
  assign pop    = main_v & out_ready;

  // Next occupancy and which entry loads; flush overrides every handshake.
  always_comb begin
    state_d        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        // in_ready is low in FULL, so only a pop can happen here.
        ST_FULL: if (pop) begin
          state_d        = ST_ONE;
          main_from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy and registered ready; ready drops on the edge that fills the skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_d;
      in_ready <= (state_d != ST_FULL);
    end
  end

  // Main entry: loads from the input or promotes the skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                main_q <= '0;
    else if (load_main)      main_q <= in_e;
    else if (main_from_skid) main_q <= skid_q;
  end

  // Skid entry: only captures when main is held by EX back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           skid_q <= '0;
    else if (load_skid) skid_q <= in_e;
  end

  // Saturating back-pressure counter; flush cycles are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (main_v && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Bubbles carry a zero control word so no write enable leaks into EX.
  assign out_valid   = main_v;
  assign out_ctrl    = main_v ? main_q.ctrl : '0;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_vrs1    = main_q.vrs1;
  assign out_vrs2    = main_q.vrs2;
  assign out_rs1_idx = main_q.rs1_idx;
  assign out_rs2_idx = main_q.rs2_idx;
  assign out_rd      = main_q.rd;

endmodule
